// File: rtl/sq_arb_pkg.sv
// rtl/sq_arb_pkg.sv - Shared widths and FSM encoding for the squaring ROM arbiter.
package sq_arb_pkg;

    localparam int N_W_DEF  = 4;
    localparam int SQ_W_DEF = 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = S_IDLE,
        LOOKUP = S_LOOKUP,
        RESP   = S_RESP
    } state_t;

endpackage

// File: rtl/sq_lookup.sv
// rtl/sq_lookup.sv - Combinational 32-entry squaring ROM indexed by {sign, n}.
module sq_lookup
    import sq_arb_pkg::*;
(
    input  logic [N_W_DEF-1:0]  n,
    input  logic                sign,
    output logic [SQ_W_DEF-1:0] square
);

    // Lower half: unsigned 0..15; upper half: two's complement -8..+7.
    always_comb begin
        square = '0;
        case ({sign, n})
            5'd0:  square = 8'd0;    5'd1:  square = 8'd1;
            5'd2:  square = 8'd4;    5'd3:  square = 8'd9;
            5'd4:  square = 8'd16;   5'd5:  square = 8'd25;
            5'd6:  square = 8'd36;   5'd7:  square = 8'd49;
            5'd8:  square = 8'd64;   5'd9:  square = 8'd81;
            5'd10: square = 8'd100;  5'd11: square = 8'd121;
            5'd12: square = 8'd144;  5'd13: square = 8'd169;
            5'd14: square = 8'd196;  5'd15: square = 8'd225;
            5'd16: square = 8'd0;    5'd17: square = 8'd1;
            5'd18: square = 8'd4;    5'd19: square = 8'd9;
            5'd20: square = 8'd16;   5'd21: square = 8'd25;
            5'd22: square = 8'd36;   5'd23: square = 8'd49;
            5'd24: square = 8'd64;   5'd25: square = 8'd49;
            5'd26: square = 8'd36;   5'd27: square = 8'd25;
            5'd28: square = 8'd16;   5'd29: square = 8'd9;
            5'd30: square = 8'd4;    5'd31: square = 8'd1;
            default: square = '0;
        endcase
    end

endmodule

// File: rtl/sq_rom_arbiter.sv
// rtl/sq_rom_arbiter.sv - Two-requester arbiter around a shared squaring ROM (SQ_RR_FAIR_EN selects round-robin).
module sq_rom_arbiter
    import sq_arb_pkg::*;
#(
    parameter int N_W  = N_W_DEF,
    parameter int SQ_W = SQ_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [N_W-1:0]  req0_n,
    input  logic            req0_sign,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [N_W-1:0]  req1_n,
    input  logic            req1_sign,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [SQ_W-1:0] rsp_data,
    output logic            rsp_id
);

    state_t          state, state_nx;
    logic            grant0, grant1;
    logic [N_W-1:0]  op_n;
    logic            op_sign, op_id;
    logic [SQ_W-1:0] square;

`ifdef SQ_RR_FAIR_EN
    logic last_id;

    // Reset to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n)
            last_id <= 1'b1;
        else if (grant0 || grant1)
            last_id <= grant1;
    end
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && rst_n) begin
`ifdef SQ_RR_FAIR_EN
            if (req0_valid && req1_valid) begin
                grant0 = last_id;
                grant1 = !last_id;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
`else
            grant0 = req0_valid;
            grant1 = req1_valid && !req0_valid;
`endif
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state == RESP);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant0 || grant1) state_nx = LOOKUP;
            LOOKUP:  state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    sq_lookup u_lookup (
        .n      (op_n),
        .sign   (op_sign),
        .square (square)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_n     <= '0;
            op_sign  <= 1'b0;
            op_id    <= 1'b0;
            rsp_data <= '0;
            rsp_id   <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant0 || grant1) begin
                op_n    <= grant1 ? req1_n : req0_n;
                op_sign <= grant1 ? req1_sign : req0_sign;
                op_id   <= grant1;
            end
            if (state == LOOKUP) begin
                rsp_data <= square;
                rsp_id   <= op_id;
            end
        end
    end

endmodule

// File: tb/tb_sq_rom_arbiter.sv
// tb/tb_sq_rom_arbiter.sv - Self-checking bench: cycle model plus directed literal checks.
module tb_sq_rom_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req0_sign = 1'b0;
    logic       req1_valid = 1'b0, req1_sign = 1'b0;
    logic [3:0] req0_n = '0, req1_n = '0;
    logic       req0_ready, req1_ready;
    logic       rsp_valid, rsp_id;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;

    int errors = 0;
    int checks = 0;

    sq_rom_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_n(req0_n), .req0_sign(req0_sign),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_n(req1_n), .req1_sign(req1_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sq(input logic [3:0] n, input logic s);
        int v;
        v = s ? int'($signed(n)) : int'(n);
        return v * v;
    endfunction

    // Reference model: one job in flight, result visible one cycle after accept,
    // held until consumed; reset drops everything.
    bit   started = 0;
    bit   m_busy = 0;
    int   m_wait = 0;
    int   m_data = 0, m_id = 0, m_pend_data = 0, m_pend_id = 0;
    bit   m_last = 1;
    int   cyc = 0, acc_cyc = 0, rise_cyc = 0, r0_hi = 0, r1_hi = 0;
    bit   prev_v = 0;
    int   log_id[$];
    int   log_data[$];

    always @(negedge clk) begin
        bit e_r0, e_r1, e_v;
        if (started) begin
            cyc++;
            e_r0 = 0;
            e_r1 = 0;
            if (rst_n && !m_busy) begin
                if (req0_valid && req1_valid) begin
`ifdef SQ_RR_FAIR_EN
                    if (m_last) e_r0 = 1; else e_r1 = 1;
`else
                    e_r0 = 1;
`endif
                end else if (req0_valid) e_r0 = 1;
                else if (req1_valid) e_r1 = 1;
            end
            e_v = m_busy && (m_wait == 0);
            check("req0_ready", int'(req0_ready), int'(e_r0));
            check("req1_ready", int'(req1_ready), int'(e_r1));
            check("rsp_valid", int'(rsp_valid), int'(e_v));
            check("rsp_data", int'(rsp_data), m_data);
            check("rsp_id", int'(rsp_id), m_id);

            if (req0_ready) r0_hi++;
            if (req1_ready) r1_hi++;
            if ((req0_ready && req0_valid) || (req1_ready && req1_valid)) acc_cyc = cyc;
            if (rsp_valid && !prev_v) rise_cyc = cyc;
            prev_v = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                log_id.push_back(int'(rsp_id));
                log_data.push_back(int'(rsp_data));
            end

            if (!rst_n) begin
                m_busy = 0; m_data = 0; m_id = 0; m_last = 1;
            end else if (e_v && rsp_ready) begin
                m_busy = 0;
            end else if (m_busy && m_wait > 0) begin
                m_wait--;
                m_data = m_pend_data;
                m_id   = m_pend_id;
            end else if (e_r0 || e_r1) begin
                m_busy      = 1;
                m_wait      = 1;
                m_pend_id   = e_r1 ? 1 : 0;
                m_pend_data = e_r1 ? sq(req1_n, req1_sign) : sq(req0_n, req0_sign);
                m_last      = e_r1;
            end
        end
    end

    task automatic wait_rsp(input int want);
        int i = 0;
        while (log_id.size() < want && i < 30) begin
            @(posedge clk);
            i++;
        end
        check("rsp_timeout", int'(log_id.size() >= want), 1);
    endtask

    task automatic xact(input bit which, input logic [3:0] n, input logic s);
        int  base;
        bit  got = 0;
        base = log_id.size();
        @(posedge clk); #1;
        if (!which) begin req0_valid = 1; req0_n = n; req0_sign = s; end
        else        begin req1_valid = 1; req1_n = n; req1_sign = s; end
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = which ? req1_ready : req0_ready;
        end
        check("accept_timeout", int'(got), 1);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 0;
        wait_rsp(base + 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
    endtask

    initial begin
        int r0_base, base;
        bit got;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        started = 1;
        @(negedge clk);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_data", int'(rsp_data), 0);

        // Single unsigned request
        r0_base = r0_hi;
        xact(0, 4'd15, 1'b0);
        check("t1_data", log_data[$], 225);
        check("t1_id", log_id[$], 0);
        check("t1_ready_cycles", r0_hi - r0_base, 1);
        check("t1_latency", rise_cyc - acc_cyc, 2);

        // Signed edge values
        xact(1, 4'b1000, 1'b1); check("s_m8", log_data[$], 64);  check("s_m8_id", log_id[$], 1);
        xact(0, 4'b1111, 1'b1); check("s_m1", log_data[$], 1);
        xact(0, 4'b0111, 1'b1); check("s_p7", log_data[$], 49);

        // Full sweep, alternating requester
        for (int k = 0; k < 32; k++) xact(k[0], k[3:0], k[4]);

        // Contention from a fresh pointer
        do_reset();
        base = log_id.size();
        @(posedge clk); #1;
        req0_valid = 1; req0_n = 4'd2; req0_sign = 0;
        req1_valid = 1; req1_n = 4'd3; req1_sign = 0;
        wait_rsp(base + 4);
        #1 req0_valid = 0; req1_valid = 0;
`ifdef SQ_RR_FAIR_EN
        check("cont0", log_id[base], 0); check("cont1", log_id[base+1], 1);
        check("cont2", log_id[base+2], 0); check("cont3", log_id[base+3], 1);
`else
        check("cont0", log_id[base], 0); check("cont1", log_id[base+1], 0);
        check("cont2", log_id[base+2], 0); check("cont3", log_id[base+3], 0);
`endif
        repeat (4) @(posedge clk);

        // Backpressure with a competing request pending
        rsp_ready = 0;
        base = log_id.size();
        #1 req0_valid = 1; req0_n = 4'd5; req0_sign = 0;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin @(negedge clk); got = req0_ready; end
        check("bp_accept", int'(got), 1);
        @(posedge clk); #1 req0_valid = 0;
        req1_valid = 1; req1_n = 4'd6; req1_sign = 1;
        @(negedge clk);
        repeat (5) @(negedge clk);
        check("bp_valid", int'(rsp_valid), 1);
        check("bp_data", int'(rsp_data), 25);
        check("bp_id", int'(rsp_id), 0);
        @(posedge clk); #1 rsp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_accept", int'(req1_ready), 1);
        @(posedge clk); #1 req1_valid = 0;
        wait_rsp(base + 2);
        check("bp_next_data", log_data[base+1], 36);
        check("bp_next_id", log_id[base+1], 1);

        // Reset during LOOKUP
        @(posedge clk); #1 req0_valid = 1; req0_n = 4'd7; req0_sign = 0;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin @(negedge clk); got = req0_ready; end
        check("ro_accept", int'(got), 1);
        @(posedge clk); #1 req0_valid = 0; rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        check("ro_valid", int'(rsp_valid), 0);
        check("ro_data", int'(rsp_data), 0);
        base = log_id.size();
        xact(1, 4'd3, 1'b0);
        repeat (5) @(posedge clk);
        check("ro_count", log_id.size() - base, 1);
        check("ro_rdata", log_data[base], 9);
        check("ro_rid", log_id[base], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
